// File: rtl/random_generator.sv
`timescale 1ns/1ps
// random_generator: free-running 8-bit maximal-length Fibonacci LFSR
// (x^8 + x^6 + x^5 + x^4 + 1, period 255), one step per rising clock edge.
// Ports:
//   clock        - system clock, state advances on the rising edge
//   nreset       - asynchronous active-low reset, loads SEED
//   rng_out      - full 8-bit LFSR state, straight from the state register
//   rng_out_3bit - low three bits of the same register
module random_generator #(
   parameter logic [7:0] SEED = 8'h01
) (
   input  logic       clock,
   input  logic       nreset,
   output logic [7:0] rng_out,
   output logic [2:0] rng_out_3bit
);

   localparam int unsigned W = 8;

   logic [W-1:0] state;
   logic [W-1:0] state_next;
   logic         fb;

   // Next-state: shift left with tap feedback; an all-zero state (SEED of 0
   // or corruption) is forced to 1 so the LFSR can never lock up.
   always_comb begin
      fb         = state[7] ^ state[5] ^ state[4] ^ state[3];
      state_next = {state[W-2:0], fb};
      if (state == '0) begin
         state_next = W'(1);
      end
   end

   // State register.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         state <= SEED;
      end else begin
         state <= state_next;
      end
   end

   assign rng_out      = state;
   assign rng_out_3bit = state[2:0];

endmodule

// File: tb/tb_random_generator.sv
`timescale 1ns/1ps
module tb_random_generator;

   logic       clock  = 1'b0;
   logic       nreset = 1'b1;
   logic [7:0] out_d, out_z, out_a;
   logic [2:0] o3_d, o3_z, o3_a;

   random_generator u_def (
      .clock(clock), .nreset(nreset), .rng_out(out_d), .rng_out_3bit(o3_d));
   random_generator #(.SEED(8'h00)) u_zero (
      .clock(clock), .nreset(nreset), .rng_out(out_z), .rng_out_3bit(o3_z));
   random_generator #(.SEED(8'hA5)) u_a5 (
      .clock(clock), .nreset(nreset), .rng_out(out_a), .rng_out_3bit(o3_a));

   typedef struct {
      logic [7:0] d;
      logic [7:0] z;
      logic [7:0] a;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] seq01 [255];
   logic [7:0] seqa5 [255];
   int         checks = 0;
   int         errors = 0;
   int         k      = 0;
   int         seen   [256];
   int         seen3  [8];
   bit         cov_on = 1'b0;

   always #10 clock = ~clock;

   // Reference: one step of the polynomial as plain arithmetic (double, then
   // add the parity of the tapped bits 7,5,4,3 = mask 0xB8 into bit 0).
   function automatic logic [7:0] poly_step(input logic [7:0] s);
      int v;
      v = ((int'(s) * 2) % 256) + ($countones(s & 8'hB8) % 2);
      return 8'(v);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Step counter since the last reset release; expectations index tables.
   always @(posedge clock or negedge nreset) begin
      if (!nreset) k <= 0;
      else         k <= k + 1;
   end

   // Scoreboard producer: expected outputs for the half-cycle just settled.
   always @(negedge clock) begin
      exp_t e;
      e.d = seq01[k % 255];
      e.a = seqa5[k % 255];
      e.z = (k == 0) ? 8'h00 : seq01[(k - 1) % 255];
      exp_q.push_back(e);
   end

   // Monitor: pops and compares, decoupled from stimulus.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         #1;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: no expectation at %0t", $time);
         end else begin
            e = exp_q.pop_front();
            chk("def_rng_out",  int'(out_d), int'(e.d));
            chk("def_rng_3bit", int'(o3_d),  int'(e.d[2:0]));
            chk("zero_rng_out", int'(out_z), int'(e.z));
            chk("zero_rng_3bit", int'(o3_z), int'(e.z[2:0]));
            chk("a5_rng_out",   int'(out_a), int'(e.a));
            chk("a5_rng_3bit",  int'(o3_a),  int'(e.a[2:0]));
         end
         if (cov_on) begin
            seen[out_d]++;
            seen3[o3_d]++;
         end
      end
   end

   // Stimulus.
   initial begin
      int distinct;
      logic [7:0] s;
      s = 8'h01;
      for (int i = 0; i < 255; i++) begin
         seq01[i] = s;
         s = poly_step(s);
      end
      s = 8'hA5;
      for (int i = 0; i < 255; i++) begin
         seqa5[i] = s;
         s = poly_step(s);
      end
      for (int i = 0; i < 256; i++) seen[i] = 0;
      for (int i = 0; i < 8; i++) seen3[i] = 0;

      #1 nreset = 1'b0;
      #24 nreset = 1'b1;

      // Full period after release.
      cov_on = 1'b1;
      repeat (255) @(posedge clock);
      @(negedge clock);
      #2 cov_on = 1'b0;
      distinct = 0;
      for (int v = 1; v < 256; v++) if (seen[v] == 1) distinct++;
      chk("cov_distinct_nonzero", distinct, 255);
      chk("cov_zero_count", seen[0], 0);
      chk("cov_3bit_zero", seen3[0], 31);
      for (int v = 1; v < 8; v++) chk("cov_3bit_nonzero", seen3[v], 32);

      // Random asynchronous resets between edges, random run lengths.
      for (int b = 0; b < 10; b++) begin
         @(posedge clock);
         #($urandom_range(2, 7));
         nreset = 1'b0;
         repeat ($urandom_range(1, 3)) @(negedge clock);
         #3 nreset = 1'b1;
         repeat ($urandom_range(3, 300)) @(posedge clock);
      end

      @(negedge clock);
      #3;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
